fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_unit.sv | 86 ++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Bundle of controller strobes, memory bus and decode fields exchanged with fetch_unit.
// The controller/testbench side uses the master modport and fetch_unit uses the slave modport.
interface fetch_unit_if #(
   parameter int PC_W  = 8,
   parameter int IW    = 16,
   parameter int CNT_W = 16
);
   logic             load_pc;
   logic             clear_pc;
   logic             load_ir;
   logic             load_addr;
   logic             sel_addr;
   logic [IW-1:0]    mem_rdata;
   logic [IW-1:0]    datapath_out;
   logic [PC_W-1:0]  mem_addr;
   logic [PC_W-1:0]  pc;
   logic [IW-1:0]    ir;
   logic             ir_valid;
   logic [2:0]       opcode;
   logic [1:0]       ALU_op;
   logic [2:0]       rn;
   logic [2:0]       rd;
   logic [2:0]       rm;
   logic [1:0]       shift_op;
   logic [IW-1:0]    sximm8;
   logic [IW-1:0]    sximm5;
   logic             halted;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output load_pc, clear_pc, load_ir, load_addr, sel_addr, mem_rdata, datapath_out,
      input  mem_addr, pc, ir, ir_valid, opcode, ALU_op, rn, rd, rm, shift_op,
             sximm8, sximm5, halted, instr_count
   );

   modport slave (
      input  load_pc, clear_pc, load_ir, load_addr, sel_addr, mem_rdata, datapath_out,
      output mem_addr, pc, ir, ir_valid, opcode, ALU_op, rn, rd, rm, shift_op,
             sximm8, sximm5, halted, instr_count
   );
endinterface

// File: rtl/fetch_unit.sv
// Fetch/decode stage: PC, data address register and IR, with a HALT-induced freeze.
// Define FETCH_INSTR_COUNT_EN to build the saturating retired-instruction counter.
module fetch_unit #(
   parameter int PC_W  = 8,
   parameter int IW    = 16,
   parameter int CNT_W = 16
) (
   input logic         clk,
   input logic         rst_n,
   fetch_unit_if.slave bus
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] dar_q;
   logic [IW-1:0]   ir_q;
   logic            ir_valid_q;
   logic            halted;
   logic            acc_pc;
   logic            acc_ir;
   logic            unused_dp_bits;

   // HALT is only meaningful once a real instruction has been captured
   assign halted = ir_valid_q & (ir_q[15:13] == 3'b111);
   assign acc_pc = bus.load_pc & ~halted;
   assign acc_ir = bus.load_ir & ~halted;

   assign unused_dp_bits = ^bus.datapath_out[IW-1:PC_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         if (acc_pc) begin
            pc_q <= bus.clear_pc ? '0 : pc_q + PC_W'(1);
         end
         if (acc_ir) begin
            ir_q       <= bus.mem_rdata;
            ir_valid_q <= 1'b1;
         end
      end
   end

   // DAR keeps loading while halted so the datapath can still address data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dar_q <= '0;
      end else if (bus.load_addr) begin
         dar_q <= bus.datapath_out[PC_W-1:0];
      end
   end

`ifdef FETCH_INSTR_COUNT_EN
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (acc_ir && (count_q != {CNT_W{1'b1}})) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign bus.instr_count = count_q;
`else
   assign bus.instr_count = '0;
`endif

   assign bus.mem_addr = bus.sel_addr ? pc_q : dar_q;
   assign bus.pc       = pc_q;
   assign bus.ir       = ir_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.halted   = halted;

   // Fixed-field decode of the 16-bit instruction word
   assign bus.opcode   = ir_q[15:13];
   assign bus.ALU_op   = ir_q[12:11];
   assign bus.rn       = ir_q[10:8];
   assign bus.rd       = ir_q[7:5];
   assign bus.shift_op = ir_q[4:3];
   assign bus.rm       = ir_q[2:0];
   assign bus.sximm8   = {{(IW-8){ir_q[7]}}, ir_q[7:0]};
   assign bus.sximm5   = {{(IW-5){ir_q[4]}}, ir_q[4:0]};

endmodule
